// File: rtl/coin_acceptor_if.sv
// coin_acceptor_if: valid/ready coin-code handshake toward the vending FSM
interface coin_acceptor_if;
  logic [1:0] coin;
  logic       coin_valid;
  logic       coin_ready;
  modport master (output coin, coin_valid, input coin_ready);
  modport slave  (input coin, coin_valid, output coin_ready);
endinterface

// File: rtl/coin_acceptor.sv
// coin_acceptor: debounces the coin sensor, classifies coins by blocking width and queues codes
module coin_acceptor #(
  parameter int DEB_CYCLES = 4,
  parameter int PENNY_MAX  = 7,
  parameter int NICKEL_MIN = 10,
  parameter int NICKEL_MAX = 15,
  parameter int DIME_MIN   = 18,
  parameter int DIME_MAX   = 26,
  parameter int TIMEOUT    = 40,
  parameter int DEPTH      = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sensor,
  coin_acceptor_if.master          bus,
  output logic                     reject,
  output logic                     jam,
  output logic [$clog2(DEPTH):0]   fifo_count
);
  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int WW = $clog2(TIMEOUT + 2);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic [1:0] {IDLE, MEASURE, CLASSIFY, JAMMED} state_t;
  state_t state, nstate;
  logic s1, s2, sdb;
  logic [DW-1:0] dcnt;
  logic [WW-1:0] w, w_nxt;
  logic [1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic is_p, is_n, is_d, pop, full, push, bad;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      sdb  <= 1'b0;
      dcnt <= '0;
    end else begin
      s1 <= sensor;
      s2 <= s1;
      if (s2 == sdb) dcnt <= '0;
      else if (dcnt == DW'(DEB_CYCLES - 1)) begin
        sdb  <= s2;
        dcnt <= '0;
      end else dcnt <= dcnt + 1'b1;
    end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      w     <= '0;
    end else begin
      state <= nstate;
      w     <= w_nxt;
    end
  always_comb begin
    nstate = state;
    w_nxt  = w;
    case (state)
      IDLE: if (sdb) begin
        nstate = MEASURE;
        w_nxt  = WW'(1);
      end
      MEASURE: if (!sdb) nstate = CLASSIFY;
        else if (w == WW'(TIMEOUT)) nstate = JAMMED;
        else w_nxt = w + 1'b1;
      CLASSIFY: nstate = IDLE;
      JAMMED: nstate = sdb ? JAMMED : IDLE;
      default: nstate = IDLE;
    endcase
  end
  assign is_p = w <= WW'(PENNY_MAX);
  assign is_n = w >= WW'(NICKEL_MIN) && w <= WW'(NICKEL_MAX);
  assign is_d = w >= WW'(DIME_MIN) && w <= WW'(DIME_MAX);
  assign pop  = bus.coin_valid & bus.coin_ready;
  // fullness is judged after this cycle's pop so a simultaneous transfer makes room
  assign full = (fifo_count - CW'(pop)) == CW'(DEPTH);
  assign bad  = !(is_p | is_n | is_d);
  assign push = state == CLASSIFY && !bad && !full;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      mem        <= '{default: '0};
      wp         <= '0;
      rp         <= '0;
      fifo_count <= '0;
      reject     <= 1'b0;
    end else begin
      if (push) begin
        mem[wp] <= is_n ? 2'd1 : is_d ? 2'd2 : 2'd0;
        wp      <= wp + 1'b1;
      end
      if (pop) rp <= rp + 1'b1;
      fifo_count <= fifo_count + CW'(push) - CW'(pop);
      reject     <= state == CLASSIFY && (bad || full);
    end
  assign jam            = state == JAMMED;
  assign bus.coin       = mem[rp];
  assign bus.coin_valid = fifo_count != '0;
endmodule

// File: tb/tb_coin_acceptor.sv
// tb_coin_acceptor: directed vector table plus hand-timed sequences for the coin acceptor
module tb_coin_acceptor;
  logic clk = 1'b0, rst = 1'b0, sensor = 1'b0;
  logic reject, jam;
  logic [2:0] fifo_count;
  int checks = 0, errors = 0, rej_cnt = 0, vcnt = 0, r0, v0;
  int xq[$];
  typedef struct {int len; int code; int push; int rej;} vec_t;
  vec_t v[14];
  coin_acceptor_if ifc();
  coin_acceptor dut (.clk(clk), .rst(rst), .sensor(sensor), .bus(ifc.master),
                     .reject(reject), .jam(jam), .fifo_count(fifo_count));
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (reject) rej_cnt++;
    if (ifc.coin_valid) vcnt++;
    if (ifc.coin_valid && ifc.coin_ready) xq.push_back(int'(ifc.coin));
  end
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic pulse(input int n);
    sensor = 1'b1;
    tick(n);
    sensor = 1'b0;
    tick(14);
  endtask
  task automatic chk_reset(input string nm);
    chk({nm, "_coin"}, int'(ifc.coin), 0);
    chk({nm, "_valid"}, int'(ifc.coin_valid), 0);
    chk({nm, "_reject"}, int'(reject), 0);
    chk({nm, "_jam"}, int'(jam), 0);
    chk({nm, "_count"}, int'(fifo_count), 0);
  endtask
  initial begin
    v[0]  = '{4, 0, 1, 0};   v[1]  = '{7, 0, 1, 0};   v[2]  = '{8, 0, 0, 1};
    v[3]  = '{9, 0, 0, 1};   v[4]  = '{10, 1, 1, 0};  v[5]  = '{15, 1, 1, 0};
    v[6]  = '{16, 0, 0, 1};  v[7]  = '{17, 0, 0, 1};  v[8]  = '{18, 2, 1, 0};
    v[9]  = '{26, 2, 1, 0};  v[10] = '{27, 0, 0, 1};  v[11] = '{40, 0, 0, 1};
    v[12] = '{41, 0, 0, 0};  v[13] = '{12, 1, 1, 0};
    ifc.coin_ready = 1'b0;
    tick(3);
    chk_reset("rst_held");
    rst = 1'b1;
    tick(3);
    chk_reset("rst_rel");
    foreach (v[i]) begin
      r0 = rej_cnt;
      pulse(v[i].len);
      chk($sformatf("w%0d_count", v[i].len), int'(fifo_count), v[i].push);
      chk($sformatf("w%0d_reject", v[i].len), rej_cnt - r0, v[i].rej);
      chk($sformatf("w%0d_jam", v[i].len), int'(jam), 0);
      if (v[i].push != 0) chk($sformatf("w%0d_code", v[i].len), int'(ifc.coin), v[i].code);
      ifc.coin_ready = 1'b1;
      tick(1);
      ifc.coin_ready = 1'b0;
      chk($sformatf("w%0d_drain", v[i].len), int'(fifo_count), 0);
    end
    xq.delete();
    v0 = vcnt;
    ifc.coin_ready = 1'b1;
    pulse(12);
    ifc.coin_ready = 1'b0;
    chk("rdy_xfers", xq.size(), 1);
    chk("rdy_code", xq.size() > 0 ? xq[0] : -1, 1);
    chk("rdy_valid_cycles", vcnt - v0, 1);
    chk("rdy_count", int'(fifo_count), 0);
    xq.delete();
    r0 = rej_cnt;
    pulse(20);
    pulse(5);
    pulse(9);
    chk("mix_count", int'(fifo_count), 2);
    chk("mix_reject", rej_cnt - r0, 1);
    chk("mix_head", int'(ifc.coin), 2);
    tick(5);
    chk("mix_hold", int'(ifc.coin), 2);
    ifc.coin_ready = 1'b1;
    tick(1);
    chk("mix_pop1_count", int'(fifo_count), 1);
    chk("mix_pop1_head", int'(ifc.coin), 0);
    tick(1);
    chk("mix_pop2_count", int'(fifo_count), 0);
    ifc.coin_ready = 1'b0;
    chk("mix_order_n", xq.size(), 2);
    chk("mix_order0", xq.size() > 0 ? xq[0] : -1, 2);
    chk("mix_order1", xq.size() > 1 ? xq[1] : -1, 0);
    r0 = rej_cnt;
    for (int k = 0; k < 3; k++) begin
      sensor = 1'b1;
      tick(k == 2 ? 3 : 2);
      sensor = 1'b0;
      tick(6);
    end
    tick(10);
    chk("glitch_count", int'(fifo_count), 0);
    chk("glitch_valid", int'(ifc.coin_valid), 0);
    chk("glitch_reject", rej_cnt - r0, 0);
    xq.delete();
    r0 = rej_cnt;
    repeat (5) pulse(12);
    chk("full_count", int'(fifo_count), 4);
    chk("full_reject", rej_cnt - r0, 1);
    r0 = rej_cnt;
    sensor = 1'b1;
    tick(12);
    sensor = 1'b0;
    tick(7);
    ifc.coin_ready = 1'b1;
    tick(1);
    ifc.coin_ready = 1'b0;
    tick(5);
    chk("fullpop_count", int'(fifo_count), 4);
    chk("fullpop_reject", rej_cnt - r0, 0);
    chk("fullpop_xfers", xq.size(), 1);
    ifc.coin_ready = 1'b1;
    tick(6);
    ifc.coin_ready = 1'b0;
    chk("fulldrain_count", int'(fifo_count), 0);
    chk("fulldrain_xfers", xq.size(), 5);
    chk("fulldrain_last", xq.size() > 0 ? xq[xq.size()-1] : -1, 1);
    r0 = rej_cnt;
    sensor = 1'b1;
    tick(46);
    chk("jam_before", int'(jam), 0);
    tick(1);
    chk("jam_rise", int'(jam), 1);
    tick(13);
    sensor = 1'b0;
    tick(6);
    chk("jam_held", int'(jam), 1);
    tick(1);
    chk("jam_fall", int'(jam), 0);
    tick(5);
    chk("jam_count", int'(fifo_count), 0);
    chk("jam_reject", rej_cnt - r0, 0);
    pulse(12);
    chk("postjam_count", int'(fifo_count), 1);
    chk("postjam_code", int'(ifc.coin), 1);
    ifc.coin_ready = 1'b1;
    tick(1);
    ifc.coin_ready = 1'b0;
    pulse(12);
    pulse(12);
    chk("prerst_count", int'(fifo_count), 2);
    r0 = rej_cnt;
    sensor = 1'b1;
    tick(10);
    rst = 1'b0;
    #1;
    chk_reset("midrst");
    tick(2);
    sensor = 1'b0;
    tick(2);
    rst = 1'b1;
    tick(10);
    chk("midrst_reject", rej_cnt - r0, 0);
    chk("midrst_count", int'(fifo_count), 0);
    xq.delete();
    pulse(20);
    chk("postrst_count", int'(fifo_count), 1);
    chk("postrst_code", int'(ifc.coin), 2);
    ifc.coin_ready = 1'b1;
    tick(3);
    ifc.coin_ready = 1'b0;
    chk("postrst_xfers", xq.size(), 1);
    chk("postrst_xcode", xq.size() > 0 ? xq[0] : -1, 2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end
endmodule

// File: doc/coin_acceptor.md
# coin_acceptor

Front-end coin acceptor feeding the ticket vending machine's `coin` input. It synchronises and debounces a raw coin-sensor line, measures how long each coin blocks the sensor, and classifies the coin as PENNY, NICKEL or DIME. Valid codes go into a small FIFO that drains to the downstream vending FSM over a valid/ready handshake. Malformed, overflowing and jammed coins are flagged and never reach the FSM.

## Interface
- `DEB_CYCLES`, 4: consecutive stable synchronised samples required to change the debounced sensor level.
- `PENNY_MAX`, 7: widths below or equal to this value classify as PENNY.
- `NICKEL_MIN` / `NICKEL_MAX`, 10 / 15: inclusive NICKEL width window.
- `DIME_MIN` / `DIME_MAX`, 18 / 26: inclusive DIME width window.
- `TIMEOUT`, 40: a width greater than this value is a jam.
- `DEPTH`, 4: FIFO entries (power of two).
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `sensor`  in  1  raw coin-sensor line, asynchronous, high while a coin blocks it.
- `coin`  out  2  FIFO head code: 0 = PENNY, 1 = NICKEL, 2 = DIME. Code 3 is never produced.
- `coin_valid`  out  1  FIFO non-empty; `coin` is meaningful.
- `coin_ready`  in  1  downstream accepts head; a transfer occurs when `coin_valid` and `coin_ready` are both high.
- `reject`  out  1  one-cycle pulse; coin dropped (bad width or FIFO full).
- `jam`  out  1  level; sensor blocked longer than `TIMEOUT`.
- `fifo_count`  out  $clog2(DEPTH)+1  current number of FIFO entries.

## Operation
- Input conditioning: `sensor` passes through a 2-flop synchroniser. The debounced level `sdb` toggles only after the synchronised value differs from `sdb` for `DEB_CYCLES` consecutive cycles. Shorter glitches are ignored.
- Width W = number of cycles `sdb` is high, measured with a saturating counter sized for `TIMEOUT`+1.
- FSM states:
  - IDLE: on `sdb`=1, go to MEASURE with W=1.
  - MEASURE: while `sdb`=1, W increments. If W would exceed `TIMEOUT`, go to JAM. On `sdb`=0, go to CLASSIFY.
  - CLASSIFY: one cycle. Decode W and push or reject, then return to IDLE.
  - JAM: `jam`=1. Stay until `sdb`=0, then go to IDLE with `jam`=0. No push and no `reject` pulse.
- Classification in CLASSIFY:
  - W ≤ `PENNY_MAX` → PENNY.
  - W in the NICKEL window → NICKEL.
  - W in the DIME window → DIME.
  - Any other W (gaps between windows, above `DIME_MAX` up to `TIMEOUT`) → `reject`, no push.
- PENNY codes are queued, not rejected. The downstream FSM owns invalid-coin handling.
- FIFO: circular buffer with read/write pointers that wrap modulo `DEPTH`. Push when full drops the coin and pulses `reject`. Push-full is evaluated against `fifo_count` after that cycle's pop, so a push when full with a simultaneous transfer is accepted. Push and pop in the same cycle leave `fifo_count` unchanged. Pop when empty is ignored.
- `coin` holds its value while `coin_valid`=1 and `coin_ready`=0.
- Reset mid-operation: the FSM returns to IDLE, the FIFO is emptied, the synchroniser, debounce state and counters clear, and any in-flight coin is discarded without `reject`.

## Timing
- Reset values: `coin`=0, `coin_valid`=0, `reject`=0, `jam`=0, `fifo_count`=0, `sdb`=0, FSM in IDLE.
- Raw `sensor` edge → `sdb` edge: 2 + `DEB_CYCLES` cycles for a clean edge.
- Let F be the first cycle MEASURE sees `sdb`=0:
  - CLASSIFY is cycle F+1.
  - Pushed entry is visible at F+2. `coin_valid` rises at F+2 if the FIFO was empty.
  - `reject` is high for exactly cycle F+2.
- `jam` rises the cycle after W would reach `TIMEOUT`+1, and falls the cycle after JAM sees `sdb`=0.
- All outputs are registered. There is no combinational path from `coin_ready` to `coin_valid` or `coin`.
- Pop latency: after a transfer, the next head appears on the following cycle.

## Test plan
- Reset, then clean 12-cycle `sensor` pulse with `coin_ready`=1 → `coin`=1 (NICKEL), `coin_valid` high one cycle, `fifo_count` back to 0.
- Pulses of 20, 5 and 9 cycles, `coin_ready`=0 → FIFO holds DIME then PENNY (`fifo_count`=2). The 9-cycle pulse pulses `reject` once. Raising `coin_ready` drains 2 then 0 in order.
- 2-cycle glitches on `sensor` → `sdb` never toggles, no push, no `reject`.
- Five NICKEL pulses, `coin_ready`=0 → `fifo_count`=4, fifth `reject`. Repeat with `coin_ready` asserted in the fifth push cycle → push accepted, count stays 4.
- `sensor` held 60 cycles → `jam`=1 from about cycle 47 (2 + `DEB_CYCLES` + `TIMEOUT` + 1), no push or `reject`. Release → `jam`=0, and the next 12-cycle pulse yields NICKEL.
- `rst` low during MEASURE with 2 entries queued → all outputs at reset values immediately, no `reject`. After release, a 20-cycle pulse yields DIME only.
